// File: rtl/array_memory_pkg.sv
// ---------------------------------------------------------------------------
// array_memory_pkg
// Shared definitions for the array memory engine:
//   - CHECK_EN : set when the macro ARRAY_MEMORY_CHECK_EN is defined; it turns on
//                the allocation/bounds error codes. 10000287 is always raised.
//   - action_e : opcodes, using the existing heap action numbering (Reset=1 .. Free=19).
//   - ERR_*    : error codes returned on rsp_error.
//   - state_e  : engine FSM states.
//   - is_scan_action() : selects the opcodes that walk the array one element per cycle.
// ---------------------------------------------------------------------------
package array_memory_pkg;

`ifdef ARRAY_MEMORY_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum logic [7:0] {
        ACT_RESET   = 8'd1,
        ACT_ALLOC   = 8'd2,
        ACT_READ    = 8'd3,
        ACT_WRITE   = 8'd4,
        ACT_SIZE    = 8'd5,
        ACT_RESIZE  = 8'd6,
        ACT_PUSH    = 8'd7,
        ACT_POP     = 8'd8,
        ACT_LESS    = 8'd9,
        ACT_GREATER = 8'd10,
        ACT_INDEX   = 8'd11,
        ACT_UP      = 8'd12,
        ACT_DOWN    = 8'd13,
        ACT_FREE    = 8'd19
    } action_e;

    localparam logic [31:0] ERR_NONE            = 32'd0;
    localparam logic [31:0] ERR_ALLOC_EXHAUSTED = 32'd10000281;
    localparam logic [31:0] ERR_DOUBLE_FREE     = 32'd10000282;
    localparam logic [31:0] ERR_UNALLOCATED     = 32'd10000283;
    localparam logic [31:0] ERR_INDEX_RANGE     = 32'd10000284;
    localparam logic [31:0] ERR_OVERFLOW        = 32'd10000285;
    localparam logic [31:0] ERR_UNDERFLOW       = 32'd10000286;
    localparam logic [31:0] ERR_UNKNOWN_ACTION  = 32'd10000287;
    localparam logic [31:0] ERR_RESIZE_TOO_BIG  = 32'd10000288;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SCAN,
        ST_RESP
    } state_e;

    function automatic logic is_scan_action(input logic [7:0] action);
        return action inside {ACT_LESS, ACT_GREATER, ACT_INDEX, ACT_UP, ACT_DOWN};
    endfunction

endpackage

// File: rtl/array_memory_engine_if.sv
// ---------------------------------------------------------------------------
// array_memory_engine_if
// Request/response handshake between the instruction sequencer (master) and
// the array memory engine (slave).
//   req_valid/req_ready : request handshake, transfer on valid && ready
//   req_action          : 8-bit opcode (array_memory_pkg::action_e)
//   req_array/index/in  : target array, element index, operand
//   rsp_valid/rsp_ready : response handshake, response held until ready
//   rsp_out / rsp_error : result (0 on error) and error code (0 = ok)
// ---------------------------------------------------------------------------
interface array_memory_engine_if #(
    parameter int ADDRESS_BITS = 2,
    parameter int INDEX_BITS   = 2,
    parameter int DATA_BITS    = 12
);
    logic                    req_valid;
    logic                    req_ready;
    logic [7:0]              req_action;
    logic [ADDRESS_BITS-1:0] req_array;
    logic [INDEX_BITS-1:0]   req_index;
    logic [DATA_BITS-1:0]    req_in;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_BITS-1:0]    rsp_out;
    logic [31:0]             rsp_error;

    modport master (
        output req_valid, req_action, req_array, req_index, req_in, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_error
    );

    modport slave (
        input  req_valid, req_action, req_array, req_index, req_in, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_error
    );
endinterface

// File: rtl/array_memory_free_finder.sv
// ---------------------------------------------------------------------------
// array_memory_free_finder
// Priority encoder over the allocation bitmap.
//   alloc_i    : one bit per array, 1 = allocated
//   free_idx_o : lowest-numbered unallocated array (0 when none is free)
//   any_free_o : at least one array is unallocated
// ---------------------------------------------------------------------------
module array_memory_free_finder #(
    parameter int ADDRESS_BITS = 2
) (
    input  logic [(1<<ADDRESS_BITS)-1:0] alloc_i,
    output logic [ADDRESS_BITS-1:0]      free_idx_o,
    output logic                         any_free_o
);
    localparam int ARRAYS = 1 << ADDRESS_BITS;

    // NOTE: every output gets a default before the loop; a path that leaves a
    // combinational output unassigned would infer a latch.
    always_comb begin
        free_idx_o = '0;
        any_free_o = 1'b0;
        // Walk downwards so the lowest free array is the last one written.
        for (int i = ARRAYS - 1; i >= 0; i--) begin
            if (!alloc_i[i]) begin
                free_idx_o = ADDRESS_BITS'(i);
                any_free_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/array_memory_engine.sv
// ---------------------------------------------------------------------------
// array_memory_engine
// Clocked, handshaked array heap: ARRAYS arrays of ARRAY_LENGTH elements with
// per-array size and allocation tracking.
//   clock : single clock, all state changes on posedge
//   reset : synchronous, active-high; abandons any in-flight operation
//   bus   : array_memory_engine_if.slave (request/response handshake)
// FSM: IDLE -> EXEC -> RESP for single-cycle ops,
//      IDLE -> SCAN -> RESP for Less/Greater/Index/Up/Down.
// SCAN visits element positions 0..LEN-1 (one per cycle) followed by one
// commit cycle that updates the size and loads the response.
// Configuration macro: ARRAY_MEMORY_CHECK_EN enables allocation/bounds error
// codes; without it only the unknown-action code is raised.
// ---------------------------------------------------------------------------
module array_memory_engine
    import array_memory_pkg::*;
#(
    parameter int ADDRESS_BITS = 2,
    parameter int INDEX_BITS   = 2,
    parameter int DATA_BITS    = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    array_memory_engine_if.slave bus
);
    localparam int ARRAYS = 1 << ADDRESS_BITS;
    localparam int LEN    = 1 << INDEX_BITS;
    localparam int SB     = INDEX_BITS + 1;   // size width: holds 0..LEN

    state_e                  state_q, state_d;
    logic [7:0]              act_q, act_d;
    logic [ADDRESS_BITS-1:0] arr_q, arr_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic [DATA_BITS-1:0]    in_q, in_d;
    logic [SB-1:0]           scan_q, scan_d;
    logic [DATA_BITS-1:0]    acc_q, acc_d;
    logic                    found_q, found_d;
    logic [DATA_BITS-1:0]    rsp_out_q, rsp_out_d;
    logic [31:0]             rsp_error_q, rsp_error_d;
    logic [ARRAYS-1:0]       alloc_q, alloc_d;
    logic [SB-1:0]           size_q [ARRAYS];
    logic [SB-1:0]           size_d [ARRAYS];

    logic [DATA_BITS-1:0]    mem_q [ARRAYS][LEN];
    logic                    mem_we;
    logic [INDEX_BITS-1:0]   mem_waddr;
    logic [DATA_BITS-1:0]    mem_wdata;

    logic [ADDRESS_BITS-1:0] free_idx;
    logic                    any_free;

    array_memory_free_finder #(
        .ADDRESS_BITS(ADDRESS_BITS)
    ) u_free_finder (
        .alloc_i   (alloc_q),
        .free_idx_o(free_idx),
        .any_free_o(any_free)
    );

    // Operand views of the captured request.
    logic [SB-1:0]         cur_size;
    logic                  cur_alloc;
    logic [SB-1:0]         idx_ext;
    logic [INDEX_BITS-1:0] last_idx;
    logic [INDEX_BITS-1:0] pos, pos_prev, pos_next;
    logic [SB-1:0]         pos_ext;
    logic                  pos_in_size;
    logic [DATA_BITS-1:0]  elem;

    assign cur_size  = size_q[arr_q];
    assign cur_alloc = alloc_q[arr_q];
    assign idx_ext   = {1'b0, idx_q};
    assign last_idx  = cur_size[INDEX_BITS-1:0] - 1'b1;

    // Up walks from the top so each shifted element is read before it is
    // overwritten; with LEN a power of two, LEN-1-i is just ~i.
    assign pos         = (act_q == ACT_UP) ? ~scan_q[INDEX_BITS-1:0] : scan_q[INDEX_BITS-1:0];
    assign pos_prev    = pos - 1'b1;
    assign pos_next    = pos + 1'b1;
    assign pos_ext     = {1'b0, pos};
    assign pos_in_size = pos_ext < cur_size;
    assign elem        = mem_q[arr_q][pos];

    // chk_err: error code for the captured request. legal: the operation can
    // actually be carried out (used when checking is off to make illegal
    // operations no-ops). Sizes do not change during a scan, so both are
    // stable from EXEC/SCAN start to the commit cycle.
    logic [31:0] chk_err;
    logic        legal;
    logic        do_op;

    always_comb begin
        chk_err = ERR_NONE;
        legal   = 1'b1;
        case (act_q)
            ACT_RESET: ;
            ACT_ALLOC: begin
                legal = any_free;
                if (!any_free) chk_err = ERR_ALLOC_EXHAUSTED;
            end
            ACT_FREE: if (!cur_alloc) chk_err = ERR_DOUBLE_FREE;
            ACT_READ, ACT_WRITE: begin
                if (!cur_alloc)                 chk_err = ERR_UNALLOCATED;
                else if (idx_ext >= cur_size)   chk_err = ERR_INDEX_RANGE;
            end
            ACT_SIZE, ACT_LESS, ACT_GREATER, ACT_INDEX: begin
                if (!cur_alloc) chk_err = ERR_UNALLOCATED;
            end
            ACT_RESIZE: begin
                legal = in_q <= DATA_BITS'(LEN);
                if (!cur_alloc)   chk_err = ERR_UNALLOCATED;
                else if (!legal)  chk_err = ERR_RESIZE_TOO_BIG;
            end
            ACT_PUSH: begin
                legal = cur_size != SB'(LEN);
                if (!cur_alloc)   chk_err = ERR_UNALLOCATED;
                else if (!legal)  chk_err = ERR_OVERFLOW;
            end
            ACT_POP: begin
                legal = cur_size != '0;
                if (!cur_alloc)   chk_err = ERR_UNALLOCATED;
                else if (!legal)  chk_err = ERR_UNDERFLOW;
            end
            ACT_UP: begin
                legal = (idx_ext <= cur_size) && (cur_size != SB'(LEN));
                if (!cur_alloc)                   chk_err = ERR_UNALLOCATED;
                else if (cur_size == SB'(LEN))    chk_err = ERR_OVERFLOW;
                else if (idx_ext > cur_size)      chk_err = ERR_INDEX_RANGE;
            end
            ACT_DOWN: begin
                legal = idx_ext < cur_size;
                if (!cur_alloc)                   chk_err = ERR_UNALLOCATED;
                else if (cur_size == '0)          chk_err = ERR_UNDERFLOW;
                else if (!legal)                  chk_err = ERR_INDEX_RANGE;
            end
            default: chk_err = ERR_UNKNOWN_ACTION;
        endcase
        if (!CHECK_EN && chk_err != ERR_UNKNOWN_ACTION) chk_err = ERR_NONE;
    end

    assign do_op = legal && (chk_err == ERR_NONE);

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        arr_d       = arr_q;
        idx_d       = idx_q;
        in_d        = in_q;
        scan_d      = scan_q;
        acc_d       = acc_q;
        found_d     = found_q;
        rsp_out_d   = rsp_out_q;
        rsp_error_d = rsp_error_q;
        alloc_d     = alloc_q;
        size_d      = size_q;
        mem_we      = 1'b0;
        mem_waddr   = idx_q;
        mem_wdata   = in_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    act_d   = bus.req_action;
                    arr_d   = bus.req_array;
                    idx_d   = bus.req_index;
                    in_d    = bus.req_in;
                    scan_d  = '0;
                    acc_d   = '0;
                    found_d = 1'b0;
                    state_d = is_scan_action(bus.req_action) ? ST_SCAN : ST_EXEC;
                end
            end

            ST_EXEC: begin
                rsp_out_d   = '0;
                rsp_error_d = chk_err;
                state_d     = ST_RESP;
                if (do_op) begin
                    case (act_q)
                        ACT_RESET: begin
                            alloc_d = '0;
                            for (int a = 0; a < ARRAYS; a++) size_d[a] = '0;
                        end
                        ACT_ALLOC: begin
                            alloc_d[free_idx] = 1'b1;
                            size_d[free_idx]  = '0;
                            rsp_out_d         = DATA_BITS'(free_idx);
                        end
                        ACT_FREE: begin
                            alloc_d[arr_q] = 1'b0;
                            size_d[arr_q]  = '0;
                        end
                        ACT_READ:   rsp_out_d = mem_q[arr_q][idx_q];
                        ACT_WRITE:  mem_we = 1'b1;
                        ACT_SIZE:   rsp_out_d = DATA_BITS'(cur_size);
                        ACT_RESIZE: size_d[arr_q] = in_q[SB-1:0];
                        ACT_PUSH: begin
                            mem_we        = 1'b1;
                            mem_waddr     = cur_size[INDEX_BITS-1:0];
                            size_d[arr_q] = cur_size + 1'b1;
                        end
                        ACT_POP: begin
                            rsp_out_d     = mem_q[arr_q][last_idx];
                            size_d[arr_q] = cur_size - 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            ST_SCAN: begin
                if (scan_q == SB'(LEN)) begin
                    // Commit cycle: every element has been visited.
                    rsp_out_d   = '0;
                    rsp_error_d = chk_err;
                    state_d     = ST_RESP;
                    if (chk_err == ERR_NONE) begin
                        case (act_q)
                            ACT_LESS, ACT_GREATER, ACT_DOWN: rsp_out_d = acc_q;
                            ACT_INDEX: rsp_out_d = found_q ? acc_q : '1;
                            default: ;
                        endcase
                    end
                    if (do_op) begin
                        if (act_q == ACT_UP)   size_d[arr_q] = cur_size + 1'b1;
                        if (act_q == ACT_DOWN) size_d[arr_q] = cur_size - 1'b1;
                    end
                end else begin
                    scan_d = scan_q + 1'b1;
                    case (act_q)
                        ACT_LESS:    if (pos_in_size && elem < in_q) acc_d = acc_q + 1'b1;
                        ACT_GREATER: if (pos_in_size && elem > in_q) acc_d = acc_q + 1'b1;
                        ACT_INDEX: begin
                            if (pos_in_size && !found_q && elem == in_q) begin
                                found_d = 1'b1;
                                acc_d   = DATA_BITS'(pos);
                            end
                        end
                        ACT_UP: begin
                            if (do_op) begin
                                if (pos_ext > idx_ext && pos_ext <= cur_size) begin
                                    mem_we    = 1'b1;
                                    mem_waddr = pos;
                                    mem_wdata = mem_q[arr_q][pos_prev];
                                end else if (pos == idx_q) begin
                                    mem_we    = 1'b1;
                                    mem_waddr = pos;
                                    mem_wdata = in_q;
                                end
                            end
                        end
                        ACT_DOWN: begin
                            // Captured even when out of size so the unchecked
                            // build returns the stored element.
                            if (pos == idx_q) acc_d = elem;
                            if (do_op && pos_ext >= idx_ext && (pos_ext + 1'b1) < cur_size) begin
                                mem_we    = 1'b1;
                                mem_waddr = pos;
                                mem_wdata = mem_q[arr_q][pos_next];
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            act_q       <= '0;
            arr_q       <= '0;
            idx_q       <= '0;
            in_q        <= '0;
            scan_q      <= '0;
            acc_q       <= '0;
            found_q     <= 1'b0;
            rsp_out_q   <= '0;
            rsp_error_q <= '0;
            alloc_q     <= '0;
            for (int a = 0; a < ARRAYS; a++) size_q[a] <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            arr_q       <= arr_d;
            idx_q       <= idx_d;
            in_q        <= in_d;
            scan_q      <= scan_d;
            acc_q       <= acc_d;
            found_q     <= found_d;
            rsp_out_q   <= rsp_out_d;
            rsp_error_q <= rsp_error_d;
            alloc_q     <= alloc_d;
            size_q      <= size_d;
        end
    end

    // NOTE: element storage is deliberately not reset so it can map onto RAM;
    // sizes and the allocation bitmap define which contents are meaningful.
    // A write is dropped in a reset cycle because the operation is abandoned.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) mem_q[arr_q][mem_waddr] <= mem_wdata;
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_array_memory_engine.sv
// ---------------------------------------------------------------------------
// tb_array_memory_engine
// Directed, table-driven bench for array_memory_engine (ADDRESS_BITS=2,
// INDEX_BITS=2, DATA_BITS=12). Expected error codes follow the
// ARRAY_MEMORY_CHECK_EN macro as seen by this file.
// ---------------------------------------------------------------------------
module tb_array_memory_engine;
    import array_memory_pkg::*;

`ifdef ARRAY_MEMORY_CHECK_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    localparam logic [31:0] E281 = 32'd10000281;
    localparam logic [31:0] E282 = 32'd10000282;
    localparam logic [31:0] E283 = 32'd10000283;
    localparam logic [31:0] E284 = 32'd10000284;
    localparam logic [31:0] E285 = 32'd10000285;
    localparam logic [31:0] E286 = 32'd10000286;
    localparam logic [31:0] E287 = 32'd10000287;
    localparam logic [31:0] E288 = 32'd10000288;

    logic clock;
    logic reset;

    array_memory_engine_if #(.ADDRESS_BITS(2), .INDEX_BITS(2), .DATA_BITS(12)) bus ();

    array_memory_engine #(.ADDRESS_BITS(2), .INDEX_BITS(2), .DATA_BITS(12)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ce(input logic [31:0] code);
        return CK ? code : 32'd0;
    endfunction

    typedef struct {
        logic [7:0]  act;
        logic [1:0]  arr;
        logic [1:0]  idx;
        logic [11:0] din;
        logic [11:0] exp_out;
        logic [31:0] exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [7:0] act, input logic [1:0] arr, input logic [1:0] idx,
                                input logic [11:0] din, input logic [11:0] exp_out,
                                input logic [31:0] exp_err, input int exp_lat);
        vec_t v;
        v.act = act; v.arr = arr; v.idx = idx; v.din = din;
        v.exp_out = exp_out; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endfunction

    task automatic send(input logic [7:0] act, input logic [1:0] arr, input logic [1:0] idx,
                        input logic [11:0] din);
        int waited;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_action = act;
        bus.req_array  = arr;
        bus.req_index  = idx;
        bus.req_in     = din;
        waited = 0;
        while (!bus.req_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("req_ready_before_accept", bus.req_ready, 1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
    endtask

    // Returns the cycle (relative to the accept cycle) in which rsp_valid rises.
    task automatic wait_rsp(output int lat);
        lat = 1;
        @(negedge clock);
        while (!bus.rsp_valid && lat < 50) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        check("rsp_valid_within_budget", bus.rsp_valid, 1);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic do_req(input logic [7:0] act, input logic [1:0] arr, input logic [1:0] idx,
                          input logic [11:0] din, output logic [11:0] out,
                          output logic [31:0] err, output int lat);
        send(act, arr, idx, din);
        wait_rsp(lat);
        out = bus.rsp_out;
        err = bus.rsp_error;
        consume();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] out;
        logic [31:0] err;
        int          lat;

        bus.req_valid  = 1'b0;
        bus.req_action = '0;
        bus.req_array  = '0;
        bus.req_index  = '0;
        bus.req_in     = '0;
        bus.rsp_ready  = 1'b0;
        reset          = 1'b1;

        // Test 1: allocation
        add(ACT_RESET,   0, 0, 0,       0,      0,          2);
        add(ACT_ALLOC,   0, 0, 0,       0,      0,          2);
        add(ACT_ALLOC,   0, 0, 0,       1,      0,          2);
        add(ACT_ALLOC,   0, 0, 0,       2,      0,          2);
        add(ACT_ALLOC,   0, 0, 0,       3,      0,          2);
        add(ACT_ALLOC,   0, 0, 0,       0,      ce(E281),   2);
        // Test 2: push and compare scans
        add(ACT_PUSH,    0, 0, 5,       0,      0,          2);
        add(ACT_PUSH,    0, 0, 3,       0,      0,          2);
        add(ACT_PUSH,    0, 0, 9,       0,      0,          2);
        add(ACT_SIZE,    0, 0, 0,       3,      0,          2);
        add(ACT_GREATER, 0, 0, 4,       2,      0,          6);
        add(ACT_LESS,    0, 0, 4,       1,      0,          6);
        // Test 3: insert, overflow, delete, search
        add(ACT_UP,      0, 1, 7,       0,      0,          6);
        add(ACT_READ,    0, 0, 0,       5,      0,          2);
        add(ACT_READ,    0, 1, 0,       7,      0,          2);
        add(ACT_READ,    0, 2, 0,       3,      0,          2);
        add(ACT_READ,    0, 3, 0,       9,      0,          2);
        add(ACT_SIZE,    0, 0, 0,       4,      0,          2);
        add(ACT_PUSH,    0, 0, 1,       0,      ce(E285),   2);
        add(ACT_READ,    0, 3, 0,       9,      0,          2);
        add(ACT_DOWN,    0, 0, 0,       5,      0,          6);
        add(ACT_SIZE,    0, 0, 0,       3,      0,          2);
        add(ACT_READ,    0, 0, 0,       7,      0,          2);
        add(ACT_READ,    0, 2, 0,       9,      0,          2);
        add(ACT_INDEX,   0, 0, 99,      12'hFFF, 0,         6);
        add(ACT_INDEX,   0, 0, 9,       2,      0,          6);
        // Out-of-size read/write on array 0 (contents 7,3,9 | 9)
        add(ACT_READ,    0, 3, 0,       CK ? 12'h0 : 12'h9,  ce(E284), 2);
        add(ACT_WRITE,   0, 3, 12'h77,  0,      ce(E284),   2);
        add(ACT_READ,    0, 3, 0,       CK ? 12'h0 : 12'h9 + 12'h6E, ce(E284), 2);
        add(ACT_SIZE,    0, 0, 0,       3,      0,          2);
        // Test 4: free handling
        add(ACT_PUSH,    2, 0, 12'h42,  0,      0,          2);
        add(ACT_FREE,    2, 0, 0,       0,      0,          2);
        add(ACT_FREE,    2, 0, 0,       0,      ce(E282),   2);
        add(ACT_READ,    2, 0, 0,       CK ? 12'h0 : 12'h42, ce(E283), 2);
        add(ACT_ALLOC,   0, 0, 0,       2,      0,          2);
        // Test 6: underflow and unknown action
        add(ACT_POP,     1, 0, 0,       0,      ce(E286),   2);
        add(8'd99,       1, 0, 0,       0,      E287,       2);
        // Resize bounds
        add(ACT_RESIZE,  1, 0, 5,       0,      ce(E288),   2);
        add(ACT_SIZE,    1, 0, 0,       0,      0,          2);
        add(ACT_RESIZE,  1, 0, 2,       0,      0,          2);
        add(ACT_SIZE,    1, 0, 0,       2,      0,          2);
        // Empty array scan, append via Up, Up past size
        add(ACT_LESS,    3, 0, 5,       0,      0,          6);
        add(ACT_UP,      3, 0, 12'hABC, 0,      0,          6);
        add(ACT_READ,    3, 0, 0,       12'hABC, 0,         2);
        add(ACT_UP,      3, 2, 1,       0,      ce(E284),   6);
        add(ACT_SIZE,    3, 0, 0,       1,      0,          2);

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_req_ready", bus.req_ready, 1);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_out",   bus.rsp_out, 0);
        check("reset_rsp_error", bus.rsp_error, 0);

        foreach (vecs[k]) begin
            do_req(vecs[k].act, vecs[k].arr, vecs[k].idx, vecs[k].din, out, err, lat);
            check($sformatf("vec%0d_out", k), out, vecs[k].exp_out);
            check($sformatf("vec%0d_err", k), err, vecs[k].exp_err);
            check($sformatf("vec%0d_latency", k), lat, vecs[k].exp_lat);
        end

        // Test 5a: response held while rsp_ready is low (array 0 size is 3)
        send(ACT_SIZE, 0, 0, 0);
        wait_rsp(lat);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check($sformatf("hold%0d_rsp_valid", c), bus.rsp_valid, 1);
            check($sformatf("hold%0d_rsp_out", c),   bus.rsp_out, 3);
            check($sformatf("hold%0d_req_ready", c), bus.req_ready, 0);
        end
        consume();

        // Test 5b: reset in the middle of a scan abandons it silently
        send(ACT_LESS, 0, 0, 100);
        repeat (2) @(negedge clock);
        check("midscan_busy", bus.req_ready, 0);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midscan_rsp_valid", bus.rsp_valid, 0);
        check("midscan_req_ready", bus.req_ready, 1);
        repeat (8) @(negedge clock);
        check("midscan_no_late_rsp", bus.rsp_valid, 0);
        do_req(ACT_SIZE, 0, 0, 0, out, err, lat);
        check("post_reset_size0_out", out, 0);
        check("post_reset_size0_err", err, ce(E283));
        do_req(ACT_SIZE, 3, 0, 0, out, err, lat);
        check("post_reset_size3_out", out, 0);
        check("post_reset_size3_err", err, ce(E283));
        do_req(ACT_ALLOC, 0, 0, 0, out, err, lat);
        check("post_reset_alloc_out", out, 0);
        check("post_reset_alloc_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
